serial_add_seq: RTL and testbench

Bit-serial multi-bit adder that sequences operand bits LSB-first through one instance of the team's 1-bit full adder `adder` (positional ports a, b, cin, sum, cout). It holds the carry in a flip-flop between cycles and assembles the WIDTH-bit result. It sits directly upstream of, and drives, the full-adder cell. It provides a start/busy/done handshake, so it can replace a WIDTH-wide ripple adder when area matters more than latency.

---
 rtl/serial_add_seq.sv | 119 +++++++++++
 tb/tb_serial_add_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder: walks the operands LSB-first through a single full-adder
// cell, keeping the carry in a flop and assembling the result in a shift register.

module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sr_shift;

    adder u_fa (sa_q[0], sb_q[0], c_q, fa_sum, fa_cout);

    // New bit enters at the MSB; written as a whole-vector shift so WIDTH=1 needs no special case.
    assign sr_shift = (sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_shift;
                c_d   = fa_cout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = sr_shift;
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a request; an unused encoding recovers the same way.
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    sr_d    = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: 8-bit directed/random operations and
// an exhaustive back-to-back 4-bit sweep, against plain-arithmetic expectations.

module tb_serial_add_seq;
    logic       clk;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_sum8 = 8'h00;
    logic       prev_cout8 = 1'b0;
    logic [3:0] prev_sum4 = 4'h0;
    logic       prev_cout4 = 1'b0;

    serial_add_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation. Inputs change on negedges; outputs are sampled on negedges.
    // After accept edge E0 the result must appear after E8 and done must be gone after E9.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input bit noisy);
        logic [8:0] expv;
        int dones;
        expv  = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        dones = 0;
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int k = 0; k <= 9; k++) begin
            chk($sformatf("w8 busy k=%0d", k), {31'd0, busy8}, {31'd0, (k < 8)});
            chk($sformatf("w8 done k=%0d", k), {31'd0, done8}, {31'd0, (k == 8)});
            if (done8 === 1'b1) dones++;
            if (k < 8) begin
                chk($sformatf("w8 sum hold k=%0d", k), {24'd0, sum8}, {24'd0, prev_sum8});
                chk($sformatf("w8 cout hold k=%0d", k), {31'd0, cout8}, {31'd0, prev_cout8});
            end else begin
                chk("w8 sum", {24'd0, sum8}, {24'd0, expv[7:0]});
                chk("w8 cout", {31'd0, cout8}, {31'd0, expv[8]});
            end
            if (noisy && (k == 2 || k == 4)) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end else begin
                start8 = 1'b0;
                if (noisy) begin a8 = 8'($urandom); b8 = 8'($urandom); end
            end
            if (k < 9) @(negedge clk);
        end
        chk("w8 done pulses", dones, 1);
        prev_sum8  = expv[7:0];
        prev_cout8 = expv[8];
        $display("op8 a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d (expected %02h/%0d)",
                 ta, tb, tc, sum8, cout8, expv[7:0], expv[8]);
    endtask

    initial begin
        logic [4:0] e4;
        int dones;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #3;
        chk("reset busy", {31'd0, busy8}, 32'd0);
        chk("reset done", {31'd0, done8}, 32'd0);
        chk("reset sum", {24'd0, sum8}, 32'd0);
        chk("reset cout", {31'd0, cout8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op8(8'h00, 8'h00, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'hA5, 8'h5A, 1'b1, 1'b0);
        op8(8'h3C, 8'h42, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'(r & 1));

        // Reset mid-RUN: drop rst_n between edges, after E4.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset busy", {31'd0, busy8}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", {31'd0, busy8}, 32'd0);
        chk("async rst done", {31'd0, done8}, 32'd0);
        chk("async rst sum", {24'd0, sum8}, 32'd0);
        chk("async rst cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum8 = 8'h00; prev_cout8 = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) dones++;
        end
        chk("no activity after reset", dones, 0);
        $display("reset mid-run: busy=%0d done=%0d sum=%02h cout=%0d", busy8, done8, sum8, cout8);
        op8(8'h01, 8'h02, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep, each new start issued during the DONE cycle.
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            logic [3:0] ta, tb;
            logic tc;
            ta = i[3:0]; tb = i[7:4]; tc = i[8];
            e4 = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
            start4 = 1'b1; a4 = ta; b4 = tb; cin4 = tc;
            @(negedge clk);
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("w4 busy i=%0d k=%0d", i, k), {31'd0, busy4}, 32'd1);
                chk($sformatf("w4 done i=%0d k=%0d", i, k), {31'd0, done4}, 32'd0);
                chk($sformatf("w4 hold i=%0d k=%0d", i, k), {27'd0, cout4, sum4}, {27'd0, prev_cout4, prev_sum4});
                @(negedge clk);
            end
            chk($sformatf("w4 done spacing i=%0d", i), {31'd0, done4}, 32'd1);
            chk($sformatf("w4 result i=%0d", i), {27'd0, cout4, sum4}, {27'd0, e4});
            prev_sum4 = e4[3:0]; prev_cout4 = e4[4];
            $display("op4 a=%0h b=%0h cin=%0d -> cout,sum=%02h (expected %02h)", ta, tb, tc, {cout4, sum4}, e4);
        end
        start4 = 1'b0;
        @(negedge clk);
        chk("w4 idle after sweep", {30'd0, busy4, done4}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
